// File: rtl/exec_sequencer_if.sv
// Control/handshake bundle between the exec sequencer and the datapath/memories.
// master = sequencer side, slave = datapath side.
interface exec_sequencer_if;
    logic [6:0] opcode_i;
    logic       Cnd_i;
    logic       imem_ready_i;
    logic       dmem_ready_i;
    logic       imem_req_o;
    logic       ir_we_o;
    logic       set_cc_o;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic       rf_we_o;
    logic       pc_we_o;
    logic [1:0] pc_sel_o;
    logic [2:0] state_o;
    logic       halted_o;
    logic [1:0] trap_cause_o;

    modport master (
        input  opcode_i, Cnd_i, imem_ready_i, dmem_ready_i,
        output imem_req_o, ir_we_o, set_cc_o, dmem_req_o, dmem_we_o,
               rf_we_o, pc_we_o, pc_sel_o, state_o, halted_o, trap_cause_o
    );

    modport slave (
        output opcode_i, Cnd_i, imem_ready_i, dmem_ready_i,
        input  imem_req_o, ir_we_o, set_cc_o, dmem_req_o, dmem_we_o,
               rf_we_o, pc_we_o, pc_sel_o, state_o, halted_o, trap_cause_o
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for the single-issue RISC-V datapath.
// Optional memory-handshake watchdog enabled by defining SEQ_TIMEOUT_EN.
module exec_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clk_i,
    input logic              rst_i,
    exec_sequencer_if.master bus
);
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [SEL_W-1:0] SEL_PC4  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_VALE = 2'b01;
    localparam logic [SEL_W-1:0] SEL_JALR = 2'b10;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // A zero watchdog limit would give a zero-width counter.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("exec_sequencer: TIMEOUT_CYCLES must be non-zero");
    end

    state_t               state_q, state_d;
    logic [OPC_W-1:0]     op_q, op_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 legal_c;
    logic                 waiting_c;
    logic                 timeout_c;

    logic                 imem_req_c;
    logic                 ir_we_c;
    logic                 set_cc_c;
    logic                 dmem_req_c;
    logic                 dmem_we_c;
    logic                 rf_we_c;
    logic                 pc_we_c;
    logic [SEL_W-1:0]     pc_sel_c;

    // Opcode legality on the live instruction-register field.
    always_comb begin
        legal_c = 1'b0;
        case (bus.opcode_i)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: legal_c = 1'b1;
            default:                                            legal_c = 1'b0;
        endcase
    end

    assign waiting_c = ((state_q == S_FETCH) && !bus.imem_ready_i) ||
                       ((state_q == S_MEM)   && !bus.dmem_ready_i);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Trap on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout_c = waiting_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and strobe decode; later states look only at the latched op_q.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cause_d    = cause_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        set_cc_c   = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = SEL_PC4;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready_i) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_DECODE: begin
                op_d = bus.opcode_i;
                if (!legal_c) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (bus.opcode_i == OPC_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                set_cc_c = (op_q == OPC_BRANCH);
                if ((op_q == OPC_LOAD) || (op_q == OPC_STORE)) begin
                    state_d = S_MEM;
                end else if (op_q == OPC_BRANCH) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = bus.Cnd_i ? SEL_VALE : SEL_PC4;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op_q == OPC_STORE);
                if (bus.dmem_ready_i) begin
                    if (op_q == OPC_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_c) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_WB: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                if (op_q == OPC_JAL) begin
                    pc_sel_c = SEL_VALE;
                end else if (op_q == OPC_JALR) begin
                    pc_sel_c = SEL_JALR;
                end
                state_d = S_FETCH;
            end

            S_HALT, S_TRAP: begin
                state_d = state_q;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.imem_req_o   = imem_req_c;
    // While reset is held the FSM sits in FETCH; keep the IR write quiet.
    assign bus.ir_we_o      = ir_we_c & ~rst_i;
    assign bus.set_cc_o     = set_cc_c;
    assign bus.dmem_req_o   = dmem_req_c;
    assign bus.dmem_we_o    = dmem_we_c;
    assign bus.rf_we_o      = rf_we_c;
    assign bus.pc_we_o      = pc_we_c;
    assign bus.pc_sel_o     = pc_sel_c;
    assign bus.state_o      = 3'(state_q);
    assign bus.halted_o     = (state_q == S_HALT);
    assign bus.trap_cause_o = cause_q;
endmodule
